// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store responder driving a req/gnt/rvalid
// data-memory port. Steers store lanes and byte enables, extracts and extends
// load data, stalls the pipeline while an access is in flight and flags
// misaligned or illegal accesses.
// Optional watchdog: define LSU_TIMEOUT_EN to abort REQ/WAIT after TIMEOUT cycles.
module load_store_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            mem_rd,
    input  logic            mem_wr,
    input  logic [2:0]      f3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            lsu_busy,
    output logic            ld_valid,
    output logic [XLEN-1:0] ld_data,
    output logic            lsu_err,
    output logic [1:0]      err_code,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [31:0]     dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [31:0]     dmem_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;

    logic [1:0]      state_q, state_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      off_q, off_d;
    logic            dmem_req_q, dmem_req_d;
    logic            dmem_we_q, dmem_we_d;
    logic [XLEN-1:0] dmem_addr_q, dmem_addr_d;
    logic [3:0]      dmem_be_q, dmem_be_d;
    logic [31:0]     dmem_wdata_q, dmem_wdata_d;
    logic            ld_valid_q, ld_valid_d;
    logic [XLEN-1:0] ld_data_q, ld_data_d;
    logic            lsu_err_q, lsu_err_d;
    logic [1:0]      err_code_q, err_code_d;

    logic            f3_illegal;
    logic            misaligned;
    logic            op_illegal;
    logic            accept_ok;
    logic            accept_err;
    logic [3:0]      st_be;
    logic [31:0]     st_wdata;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [31:0]     ld_ext;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned WD_W        = $clog2(TIMEOUT + 1);
    localparam logic [1:0]  ERR_TIMEOUT = 2'b11;

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic [WD_W-1:0] wdog_inc;
    logic            wdog_expired;

    // Watchdog: cleared on entry to REQ, counts every cycle spent in REQ or WAIT
    always_comb begin : wdog_next
        wdog_inc     = wdog_q + WD_W'(1);
        wdog_expired = (wdog_inc == WD_W'(TIMEOUT));
        wdog_d       = wdog_q;
        if (accept_ok) begin
            wdog_d = '0;
        end else if (state_q != ST_IDLE) begin
            wdog_d = wdog_inc;
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    // TIMEOUT only sizes the watchdog; keep it referenced when the watchdog is compiled out
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(TIMEOUT);
`endif

    // Accept-cycle legality: illegal op/f3 outranks misalignment
    always_comb begin : accept_decode
        if (mem_rd) begin
            f3_illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
        end else begin
            f3_illegal = (f3 >= 3'b011);
        end
        misaligned = ((f3[1:0] == 2'b01) && addr[0])
                  || ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        op_illegal = (mem_rd && mem_wr) || f3_illegal;
        accept_ok  = (state_q == ST_IDLE) && ex_valid && (mem_rd ^ mem_wr)
                  && !f3_illegal && !misaligned;
        accept_err = (state_q == ST_IDLE) && ex_valid && (mem_rd || mem_wr)
                  && (op_illegal || misaligned);
    end

    // Store lane steering and byte enables by access size
    always_comb begin : store_steer
        st_be    = 4'b1111;
        st_wdata = wdata[31:0];
        case (f3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << addr[1:0];
                st_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                st_be    = addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = wdata[31:0];
            end
        endcase
    end

    // Load lane extraction and sign/zero extension from the latched f3/offset
    always_comb begin : load_extract
        rd_byte = dmem_rdata[{off_q, 3'b000} +: 8];
        rd_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  ld_ext = {24'h0, rd_byte};
            3'b101:  ld_ext = {16'h0, rd_half};
            default: ld_ext = dmem_rdata;
        endcase
    end

    // FSM next state and registered-output next values
    always_comb begin : fsm_next
        state_d      = state_q;
        f3_d         = f3_q;
        off_d        = off_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_be_d    = dmem_be_q;
        dmem_wdata_d = dmem_wdata_q;
        ld_valid_d   = 1'b0;
        ld_data_d    = ld_data_q;
        lsu_err_d    = 1'b0;
        err_code_d   = err_code_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_err) begin
                    lsu_err_d  = 1'b1;
                    err_code_d = op_illegal ? ERR_ILLEGAL : ERR_MISALIGN;
                end else if (accept_ok) begin
                    state_d      = ST_REQ;
                    f3_d         = f3;
                    off_d        = addr[1:0];
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = mem_wr;
                    dmem_addr_d  = {addr[XLEN-1:2], 2'b00};
                    dmem_be_d    = st_be;
                    dmem_wdata_d = st_wdata;
                end
            end
            ST_REQ: begin
                if (dmem_gnt) begin
                    dmem_req_d = 1'b0;
                    state_d    = dmem_we_q ? ST_IDLE : ST_WAIT;
                end
`ifdef LSU_TIMEOUT_EN
                else if (wdog_expired) begin
                    dmem_req_d = 1'b0;
                    state_d    = ST_IDLE;
                    lsu_err_d  = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end
`endif
            end
            ST_WAIT: begin
                if (dmem_rvalid) begin
                    ld_data_d  = XLEN'(ld_ext);
                    ld_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end
`ifdef LSU_TIMEOUT_EN
                else if (wdog_expired) begin
                    state_d    = ST_IDLE;
                    lsu_err_d  = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end
`endif
            end
            default: begin
                state_d    = ST_IDLE;
                dmem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            f3_q         <= '0;
            off_q        <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_be_q    <= '0;
            dmem_wdata_q <= '0;
            ld_valid_q   <= 1'b0;
            ld_data_q    <= '0;
            lsu_err_q    <= 1'b0;
            err_code_q   <= '0;
        end else begin
            state_q      <= state_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_be_q    <= dmem_be_d;
            dmem_wdata_q <= dmem_wdata_d;
            ld_valid_q   <= ld_valid_d;
            ld_data_q    <= ld_data_d;
            lsu_err_q    <= lsu_err_d;
            err_code_q   <= err_code_d;
        end
    end

    // Stall in the accept cycle itself so the pipeline never overruns the LSU
    assign lsu_busy   = (state_q != ST_IDLE) || accept_ok;
    assign ld_valid   = ld_valid_q;
    assign ld_data    = ld_data_q;
    assign lsu_err    = lsu_err_q;
    assign err_code   = err_code_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_be    = dmem_be_q;
    assign dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed stimulus with a queue-based scoreboard for
// memory requests, load results and error pulses.
module tb_load_store_unit;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned TIMEOUT = 16;

    logic            clk;
    logic            rst_n;
    logic            ex_valid;
    logic            mem_rd;
    logic            mem_wr;
    logic [2:0]      f3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            lsu_busy;
    logic            ld_valid;
    logic [XLEN-1:0] ld_data;
    logic            lsu_err;
    logic [1:0]      err_code;
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [3:0]      dmem_be;
    logic [31:0]     dmem_wdata;
    logic            dmem_gnt;
    logic            dmem_rvalid;
    logic [31:0]     dmem_rdata;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_t;

    mem_t        exp_mem[$];
    logic [31:0] exp_ld[$];
    logic [1:0]  exp_err[$];

    int total = 0;
    int bad   = 0;

    load_store_unit #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .f3         (f3),
        .addr       (addr),
        .wdata      (wdata),
        .lsu_busy   (lsu_busy),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .lsu_err    (lsu_err),
        .err_code   (err_code),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_gnt   (dmem_gnt),
        .dmem_rvalid(dmem_rvalid),
        .dmem_rdata (dmem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mem_t mk_mem(input logic we, input logic [31:0] a,
                                    input logic [3:0] be, input logic [31:0] wd);
        mem_t m;
        m.we    = we;
        m.addr  = a;
        m.be    = be;
        m.wdata = wd;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        f3       = 3'b000;
        addr     = 32'h0;
        wdata    = 32'h0;
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT presents an event
    initial begin : monitor
        mem_t        m;
        logic [31:0] d;
        logic [1:0]  c;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (dmem_req && dmem_gnt) begin
                    check("mem_expected", 32'(exp_mem.size() != 0), 32'd1);
                    if (exp_mem.size() != 0) begin
                        m = exp_mem.pop_front();
                        check("mem_we", 32'(dmem_we), 32'(m.we));
                        check("mem_addr", dmem_addr, m.addr);
                        if (m.we) begin
                            check("mem_be", 32'(dmem_be), 32'(m.be));
                            check("mem_wdata", dmem_wdata, m.wdata);
                        end
                    end
                end
                if (ld_valid) begin
                    check("ld_expected", 32'(exp_ld.size() != 0), 32'd1);
                    if (exp_ld.size() != 0) begin
                        d = exp_ld.pop_front();
                        check("ld_data", ld_data, d);
                    end
                end
                if (lsu_err) begin
                    check("err_expected", 32'(exp_err.size() != 0), 32'd1);
                    if (exp_err.size() != 0) begin
                        c = exp_err.pop_front();
                        check("err_code", 32'(err_code), 32'(c));
                    end
                end
            end
        end
    end

    // Legal access: accept, optional grant delay, then store retire or load return
    task automatic run_access(input logic is_st, input logic [2:0] f, input logic [31:0] a,
                              input logic [31:0] wd, input int gnt_dly,
                              input logic [31:0] rd, input mem_t exp_m,
                              input logic [31:0] exp_data);
        ex_valid = 1'b1;
        mem_rd   = !is_st;
        mem_wr   = is_st;
        f3       = f;
        addr     = a;
        wdata    = wd;
        exp_mem.push_back(exp_m);
        if (!is_st) exp_ld.push_back(exp_data);
        #1;
        check("busy_accept", 32'(lsu_busy), 32'd1);
        tick();
        // a different instruction presented while busy must be ignored
        mem_rd = is_st;
        mem_wr = !is_st;
        f3     = 3'b000;
        addr   = 32'hFFFF_FFFF;
        wdata  = 32'h0;
        for (int i = 0; i < gnt_dly; i++) begin
            #1;
            check("req_held", 32'(dmem_req), 32'd1);
            check("addr_held", dmem_addr, exp_m.addr);
            if (is_st) begin
                check("be_held", 32'(dmem_be), 32'(exp_m.be));
                check("wdata_held", dmem_wdata, exp_m.wdata);
            end
            tick();
        end
        dmem_gnt = 1'b1;
        #1;
        check("req_at_gnt", 32'(dmem_req), 32'd1);
        check("busy_in_req", 32'(lsu_busy), 32'd1);
        tick();
        dmem_gnt = 1'b0;
        if (is_st) begin
            idle_inputs();
            #1;
            check("busy_store_done", 32'(lsu_busy), 32'd0);
            check("req_store_done", 32'(dmem_req), 32'd0);
        end else begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = rd;
            #1;
            check("busy_in_wait", 32'(lsu_busy), 32'd1);
            check("req_in_wait", 32'(dmem_req), 32'd0);
            tick();
            dmem_rvalid = 1'b0;
            dmem_rdata  = 32'h0;
            idle_inputs();
            #1;
            check("busy_load_done", 32'(lsu_busy), 32'd0);
            check("ld_valid_pulse", 32'(ld_valid), 32'd1);
            tick();
            #1;
            check("ld_valid_clear", 32'(ld_valid), 32'd0);
            check("ld_data_hold", ld_data, exp_data);
        end
    endtask

    // Rejected access: no memory request, error pulse one cycle later
    task automatic run_err(input logic rd, input logic wr, input logic [2:0] f,
                           input logic [31:0] a, input logic [1:0] code);
        ex_valid = 1'b1;
        mem_rd   = rd;
        mem_wr   = wr;
        f3       = f;
        addr     = a;
        wdata    = 32'h5555_5555;
        exp_err.push_back(code);
        #1;
        check("busy_err_accept", 32'(lsu_busy), 32'd0);
        tick();
        idle_inputs();
        #1;
        check("err_pulse", 32'(lsu_err), 32'd1);
        check("req_after_err", 32'(dmem_req), 32'd0);
        check("busy_after_err", 32'(lsu_busy), 32'd0);
        tick();
        #1;
        check("err_clear", 32'(lsu_err), 32'd0);
        check("err_code_hold", 32'(err_code), 32'(code));
    endtask

    initial begin : stimulus
        rst_n       = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        idle_inputs();
        #3;
        check("rst_busy", 32'(lsu_busy), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_ld_valid", 32'(ld_valid), 32'd0);
        check("rst_ld_data", ld_data, 32'h0);
        check("rst_err", 32'(lsu_err), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // ex_valid without an op is not an access
        ex_valid = 1'b1;
        #1;
        check("busy_no_op", 32'(lsu_busy), 32'd0);
        tick();
        idle_inputs();
        #1;
        check("req_no_op", 32'(dmem_req), 32'd0);

        // loads: word, signed/unsigned byte and half
        run_access(1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF,
                   mk_mem(1'b0, 32'h100, 4'b1111, 32'h0), 32'hDEAD_BEEF);
        run_access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 32'h80FF_FFFF,
                   mk_mem(1'b0, 32'h100, 4'b1000, 32'h0), 32'hFFFF_FF80);
        run_access(1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 32'h80FF_FFFF,
                   mk_mem(1'b0, 32'h100, 4'b1000, 32'h0), 32'h0000_0080);
        run_access(1'b0, 3'b001, 32'h0000_0102, 32'h0, 1, 32'h8001_7FFF,
                   mk_mem(1'b0, 32'h100, 4'b1100, 32'h0), 32'hFFFF_8001);
        run_access(1'b0, 3'b101, 32'h0000_0000, 32'h0, 0, 32'h1234_F00D,
                   mk_mem(1'b0, 32'h000, 4'b0011, 32'h0), 32'h0000_F00D);
        run_access(1'b0, 3'b000, 32'h0000_0101, 32'h0, 0, 32'h0000_7F00,
                   mk_mem(1'b0, 32'h100, 4'b0010, 32'h0), 32'h0000_007F);

        // stores: half with delayed grant, byte, word, low half
        run_access(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 3, 32'h0,
                   mk_mem(1'b1, 32'h200, 4'b1100, 32'hABCD_ABCD), 32'h0);
        run_access(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 1, 32'h0,
                   mk_mem(1'b1, 32'h200, 4'b0010, 32'hA5A5_A5A5), 32'h0);
        run_access(1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 0, 32'h0,
                   mk_mem(1'b1, 32'h300, 4'b1111, 32'hCAFE_F00D), 32'h0);
        run_access(1'b1, 3'b001, 32'h0000_0004, 32'h0000_BEEF, 0, 32'h0,
                   mk_mem(1'b1, 32'h004, 4'b0011, 32'hBEEF_BEEF), 32'h0);

        // error cases: misaligned, illegal f3, both ops, illegal outranks misaligned
        run_err(1'b1, 1'b0, 3'b010, 32'h0000_0101, 2'b01);
        run_err(1'b0, 1'b1, 3'b011, 32'h0000_0200, 2'b10);
        run_err(1'b1, 1'b0, 3'b001, 32'h0000_0003, 2'b01);
        run_err(1'b1, 1'b0, 3'b110, 32'h0000_0000, 2'b10);
        run_err(1'b1, 1'b1, 3'b010, 32'h0000_0000, 2'b10);
        run_err(1'b1, 1'b0, 3'b111, 32'h0000_0001, 2'b10);
        run_err(1'b0, 1'b1, 3'b010, 32'h0000_0002, 2'b01);

        // stray grant while idle is ignored
        dmem_gnt = 1'b1;
        #1;
        check("stray_gnt_busy", 32'(lsu_busy), 32'd0);
        tick();
        dmem_gnt = 1'b0;
        #1;
        check("stray_gnt_req", 32'(dmem_req), 32'd0);
        tick();

        // reset during WAIT drops the load; a stale rvalid afterwards is ignored
        ex_valid = 1'b1;
        mem_rd   = 1'b1;
        f3       = 3'b010;
        addr     = 32'h0000_0104;
        exp_mem.push_back(mk_mem(1'b0, 32'h104, 4'b1111, 32'h0));
        tick();
        idle_inputs();
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        #1;
        check("wait_busy", 32'(lsu_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(lsu_busy), 32'd0);
        check("midrst_req", 32'(dmem_req), 32'd0);
        check("midrst_ld_data", ld_data, 32'h0);
        check("midrst_err_code", 32'(err_code), 32'd0);
        check("midrst_be", 32'(dmem_be), 32'd0);
        tick();
        rst_n       = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_1111;
        #1;
        check("postrst_busy", 32'(lsu_busy), 32'd0);
        tick();
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        #1;
        check("stale_rvalid_ld_valid", 32'(ld_valid), 32'd0);
        check("stale_rvalid_ld_data", ld_data, 32'h0);
        tick();

`ifdef LSU_TIMEOUT_EN
        // grant never arrives: abort after TIMEOUT cycles in REQ
        ex_valid = 1'b1;
        mem_rd   = 1'b1;
        f3       = 3'b010;
        addr     = 32'h0000_0400;
        exp_err.push_back(2'b11);
        #1;
        check("to_busy_accept", 32'(lsu_busy), 32'd1);
        tick();
        idle_inputs();
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            #1;
            check("to_req_held", 32'(dmem_req), 32'd1);
            check("to_busy_held", 32'(lsu_busy), 32'd1);
            tick();
        end
        #1;
        check("to_err_pulse", 32'(lsu_err), 32'd1);
        check("to_req_dropped", 32'(dmem_req), 32'd0);
        check("to_busy_dropped", 32'(lsu_busy), 32'd0);
        check("to_no_ld_valid", 32'(ld_valid), 32'd0);
        tick();
        #1;
        check("to_err_clear", 32'(lsu_err), 32'd0);
        check("to_err_code_hold", 32'(err_code), 32'd3);
        tick();
`else
        // without the watchdog a long grant delay simply stalls
        run_access(1'b0, 3'b010, 32'h0000_0400, 32'h0, 20, 32'h0BAD_CAFE,
                   mk_mem(1'b0, 32'h400, 4'b1111, 32'h0), 32'h0BAD_CAFE);
`endif

        tick();
        tick();
        check("mem_queue_drained", 32'(exp_mem.size()), 32'd0);
        check("ld_queue_drained", 32'(exp_ld.size()), 32'd0);
        check("err_queue_drained", 32'(exp_err.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage responder for the control decode: consumes mem_rd/mem_wr/f3 plus the ALU-computed address and drives a req/gnt/rvalid data-memory port.
- Performs byte-lane steering and byte-enable generation for stores.
- Performs lane extraction and sign or zero extension for loads.
- Stalls the pipeline while an access is outstanding and flags misaligned or illegal accesses.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- TIMEOUT, 16, watchdog limit in cycles. Used only when LSU_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid  in  1  instruction in EX/MEM is valid this cycle
- mem_rd  in  1  load request from control decode
- mem_wr  in  1  store request from control decode
- f3  in  3  funct3: access size and signedness
- addr  in  XLEN  byte address (ALU result)
- wdata  in  XLEN  store data (rs2)
- lsu_busy  out  1  pipeline stall
- ld_valid  out  1  one-cycle pulse: ld_data is valid
- ld_data  out  XLEN  extended load result for writeback
- lsu_err  out  1  one-cycle error pulse
- err_code  out  2  01 misaligned, 10 illegal f3/op, 11 timeout; holds its last value
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  XLEN  word-aligned address, {addr[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-steered store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read word

Behaviour:
- Reset: all outputs 0; state IDLE; watchdog counter 0.
- FSM states: IDLE, REQ, WAIT.
- Accept condition: state IDLE and ex_valid and (mem_rd xor mem_wr).
- Accept-cycle checks, in priority order:
  1. Illegal f3 (load f3 in {011,110,111}; store f3 >= 011): no memory access, lsu_err pulse next cycle, err_code=10.
  2. Misaligned (half with addr[0]=1; word with addr[1:0]!=0): no memory access, lsu_err pulse next cycle, err_code=01.
  3. Otherwise: latch op/f3/addr[1:0]/wdata and go to REQ.
- ex_valid with mem_rd and mem_wr both high: illegal, err_code=10, no access.
- lsu_busy = (state != IDLE) OR (accept this cycle and no error). It is combinational so the pipeline stalls in the accept cycle itself.
- REQ: dmem_req=1, dmem_we, addr, be and wdata all held stable until dmem_gnt.
  - Store: on gnt, go to IDLE; the store is complete.
  - Load: on gnt, go to WAIT.
- Store lane steering:
  - Byte: wdata[7:0] replicated to all 4 lanes; be = 0001 << addr[1:0].
  - Half: wdata[15:0] replicated to both halves; be = addr[1] ? 1100 : 0011.
  - Word: be = 1111.
- WAIT: dmem_req=0.
  - On dmem_rvalid: select byte rdata[8*addr[1:0] +: 8] or half rdata[16*addr[1] +: 16].
  - Extend: sign-extend for f3 000/001; zero-extend for 100/101; f3 010 passes the word.
  - Register the result into ld_data, pulse ld_valid the following cycle, go to IDLE.
- ld_data holds its value until the next load completes.
- Ignored inputs:
  - dmem_gnt outside REQ.
  - dmem_rvalid outside WAIT, including stale rvalid after a reset.
  - ex_valid while busy.
- Minimum latency:
  - Load: accept T0, req T1 (gnt T1), rvalid T2, ld_valid T3.
  - Store: accept T0, req+gnt T1, IDLE T2.
- Reset mid-operation: immediate return to IDLE, all outputs cleared, the transaction is dropped.

Optional Feature:
- LSU_TIMEOUT_EN defined: a watchdog counts cycles spent in REQ or WAIT.
  - The counter clears on every entry to REQ.
  - When the count reaches TIMEOUT: abort to IDLE, lsu_err pulse, err_code=11, ld_valid not asserted, dmem_req dropped.
- LSU_TIMEOUT_EN undefined: no counter; the FSM waits indefinitely; err_code 11 is never produced.

Test Plan:
- Test 1. Stimulus: LW at addr 0x100, gnt same cycle as req, rvalid next cycle with rdata 0xDEADBEEF. Required: ld_valid at T3, ld_data 0xDEADBEEF, lsu_busy high T0-T2.
- Test 2. Stimulus: LB at 0x103 with rdata 0x80FF_FFFF, then LBU at 0x103 with the same rdata. Required: LB gives ld_data 0xFFFFFF80; LBU gives 0x00000080.
- Test 3. Stimulus: SH at 0x202 with wdata 0x1234ABCD, gnt delayed 3 cycles. Required: dmem_addr 0x200, be 1100, wdata 0xABCDABCD, all held stable 4 cycles, IDLE the cycle after gnt.
- Test 4. Stimulus: LW at 0x101, then a store with f3=011. Required: each produces no dmem_req, lsu_err pulse, err_code 01 then 10.
- Test 5. Stimulus: assert rst_n low during WAIT, then rvalid arrives after reset release. Required: outputs return to 0, stale rvalid produces no ld_valid.
- Test 6 (LSU_TIMEOUT_EN). Stimulus: load with gnt never asserted, TIMEOUT=16. Required: abort after 16 cycles in REQ, lsu_err pulse with err_code 11, lsu_busy drops.
